// File: rtl/mult_share_sched_pkg.sv
// Shared types and widths for the mult_share_sched multiplier-sharing scheduler.
package mult_sched_pkg;

  localparam int OPND_W      = 24;
  localparam int PROD_W      = 48;
  localparam int PREC_W      = 2;
  localparam int MUL_LAT_DEF = 2;

  // Precision codes forwarded untouched to the shared multiplier.
  typedef enum logic [PREC_W-1:0] {
    PREC_FULL    = 2'd0,
    PREC_HALF    = 2'd1,
    PREC_QUARTER = 2'd2,
    PREC_RSVD    = 2'd3
  } prec_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester, multiplier and drain-control signals of mult_share_sched, bundled as one interface.
interface mult_share_sched_if
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*PREC_W-1:0] req_prec;
  logic [NUM_REQ*OPND_W-1:0] req_a;
  logic [NUM_REQ*OPND_W-1:0] req_b;

  logic [PREC_W-1:0]         m_prec;
  logic [OPND_W-1:0]         m_a;
  logic [OPND_W-1:0]         m_b;
  logic [PROD_W-1:0]         m_c;

  logic [NUM_REQ-1:0]        rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [PROD_W-1:0]         rsp_data;

  logic                      drain_req;
  logic                      drain_done;

  modport slave (
    input  req_valid, req_prec, req_a, req_b, m_c, drain_req,
    output req_ready, m_prec, m_a, m_b, rsp_valid, rsp_id, rsp_data, drain_done
  );

  modport master (
    output req_valid, req_prec, req_a, req_b, m_c, drain_req,
    input  req_ready, m_prec, m_a, m_b, rsp_valid, rsp_id, rsp_data, drain_done
  );

endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap, pointer moves past each winner.
module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gid
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (enable && !found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        gid        = sel;
      end
    end
  end

  // A grant is only ever issued to a valid requester, so found means a transfer happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin issue and ID-tagged results.
// Optional per-requester grant counters are built when MULT_SCHED_STATS_EN is defined.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mult_share_sched_if.slave       bus
`ifdef MULT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   grant_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  sched_state_e                     state_q, state_d;
  logic                             grant_en;
  logic [NUM_REQ-1:0]               grant;
  logic [ID_W-1:0]                  gid;
  logic [MUL_LAT-1:0]               tag_vld;
  logic [MUL_LAT-1:0][ID_W-1:0]     tag_id;

  // Grants are also masked during reset so every output reads zero while rst is high.
  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .enable (grant_en && !rst),
    .grant  (grant),
    .gid    (gid)
  );

  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_en       = 1'b0;
    bus.drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.drain_req) state_d = ST_DRAIN;
        else               grant_en = 1'b1;
      end
      ST_DRAIN: begin
        if (!bus.drain_req)     state_d = ST_RUN;
        else if (tag_vld == '0) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        bus.drain_done = bus.drain_req;
        if (!bus.drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    bus.m_prec = '0;
    bus.m_a    = '0;
    bus.m_b    = '0;
    if (grant != '0) begin
      bus.m_prec = bus.req_prec[int'(gid)*PREC_W +: PREC_W];
      bus.m_a    = bus.req_a[int'(gid)*OPND_W +: OPND_W];
      bus.m_b    = bus.req_b[int'(gid)*OPND_W +: OPND_W];
    end
  end

  // The tag pipe mirrors the multiplier's registers so the last stage lines up with m_c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= (grant != '0);
      tag_id[0]  <= gid;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_id    = '0;
    bus.rsp_data  = '0;
    if (tag_vld[MUL_LAT-1]) begin
      bus.rsp_valid[tag_id[MUL_LAT-1]] = 1'b1;
      bus.rsp_id                       = tag_id[MUL_LAT-1];
      bus.rsp_data                     = bus.m_c;
    end
  end

`ifdef MULT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized scoreboard bench for mult_share_sched with a behavioural multiplier and arbitration model.
`timescale 1ns/1ps
module tb_mult_share_sched;
  import mult_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef struct {
    int          id;
    logic [47:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef MULT_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  mult_share_sched #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULT_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Stand-in for the shared multiplier: MUL_LAT register stages from operands to product.
  logic [47:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= {24'b0, bus.m_a} * {24'b0, bus.m_b};
    for (int s = 1; s < MUL_LAT; s++) mul_pipe[s] <= mul_pipe[s-1];
  end
  assign bus.m_c = mul_pipe[MUL_LAT-1];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   cyc      = 0;
  int   ptr_m    = 0;
  bit   dr1, dr2, x1, x2, x3;
  int   cnt_m [NUM_REQ];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic randomizeOps();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*24 +: 24]  = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      bus.req_b[i*24 +: 24]  = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      bus.req_prec[i*2 +: 2] = 2'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic dr, input int n);
    for (int c = 0; c < n; c++) begin
      randomizeOps();
      bus.req_valid = v;
      bus.drain_req = dr;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: the scheduler runs whenever drain_req was low last cycle and is low now;
  // it reports drained once drain_req has been high three cycles and nothing issued just before.
  always @(negedge clk) begin : monitor
    int                 g;
    logic [NUM_REQ-1:0] er;
    logic [23:0]        ea, eb;
    logic [1:0]         ep;
    exp_t               e;
`ifdef MULT_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0] exp_cnt;
`endif
    cyc++;
`ifdef MULT_SCHED_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) exp_cnt[i*16 +: 16] = 16'(cnt_m[i]);
    checkOutput("grant_cnt", 64'(grant_cnt), 64'(exp_cnt));
`endif
    if (rst) begin
      checkOutput("reset_outputs",
                  64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.drain_done, bus.m_prec,
                       |bus.m_a, |bus.m_b, |bus.rsp_data}), 64'(0));
      exp_q.delete();
      ptr_m = 0;
      {dr1, dr2, x1, x2, x3} = '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_m[i] = 0;
    end else begin
      g = -1;
      if (!bus.drain_req && !dr1) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && bus.req_valid[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      checkOutput("req_ready", 64'(bus.req_ready), 64'(er));
      if (g >= 0) begin
        ea = bus.req_a[g*24 +: 24];
        eb = bus.req_b[g*24 +: 24];
        ep = bus.req_prec[g*2 +: 2];
        checkOutput("m_operands", {14'b0, bus.m_prec, bus.m_a, bus.m_b}, {14'b0, ep, ea, eb});
        e.id   = g;
        e.data = {24'b0, ea} * {24'b0, eb};
        e.due  = cyc + MUL_LAT;
        exp_q.push_back(e);
        ptr_m = (g + 1) % NUM_REQ;
        if (cnt_m[g] < 65535) cnt_m[g]++;
      end else begin
        checkOutput("m_idle_zero", {14'b0, bus.m_prec, bus.m_a, bus.m_b}, 64'(0));
      end
      checkOutput("drain_done", 64'(bus.drain_done), 64'(bus.drain_req && dr1 && dr2 && !x3));

      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          er = '0;
          er[e.id] = 1'b1;
          checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(er));
          checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          checkOutput("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else begin
        checkOutput("rsp_idle_zero", 64'({bus.rsp_id, bus.rsp_data}), 64'(0));
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          e  = exp_q.pop_front();
          er = '0;
          er[e.id] = 1'b1;
          checkOutput("rsp_missing", 64'(bus.rsp_valid), 64'(er));
        end
      end

      x3  = x2;
      x2  = x1;
      x1  = (g >= 0);
      dr2 = dr1;
      dr1 = bus.drain_req;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_prec  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.drain_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single request from requester 0: 3 * 5");
    randomizeOps();
    bus.req_a[23:0]  = 24'd3;
    bus.req_b[23:0]  = 24'd5;
    bus.req_prec[1:0] = 2'd0;
    bus.req_valid    = 4'b0001;
    bus.drain_req    = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b0, 3);

    $display("[TB] pointer wrap with requesters 1 and 3");
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b1010, 1'b0, 3);
    applyStimulus(4'b0000, 1'b0, 3);

    $display("[TB] all requesters continuously valid");
    applyStimulus(4'b1111, 1'b0, 10);

    $display("[TB] back-to-back issues followed by drain");
    applyStimulus(4'b1111, 1'b1, 6);
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 4);
    applyStimulus(4'b0000, 1'b0, 3);

    $display("[TB] randomized traffic with drain bursts");
    for (int seg = 0; seg < 60; seg++) begin
      logic dr;
      int   len;
      dr  = ($urandom_range(0, 4) == 0);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) applyStimulus(NUM_REQ'($urandom), dr, 1);
    end
    applyStimulus(4'b0000, 1'b0, 4);

    $display("[TB] reset with results in flight");
    applyStimulus(4'b1111, 1'b0, 2);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.drain_done}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4);
    applyStimulus(4'b1111, 1'b0, 6);
    applyStimulus(4'b0000, 1'b0, 4);

`ifdef MULT_SCHED_STATS_EN
    $display("[TB] grant counter saturation on requester 2");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0100, 1'b0, 70000);
    applyStimulus(4'b0000, 1'b0, 3);
    checkOutput("grant_cnt_sat", 64'(grant_cnt), {16'h0000, 16'hFFFF, 16'h0000, 16'h0000});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
